// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, opcodes, capture constants and the
// 1149.1 state transition function.
package jtag_pkg;

  localparam int unsigned IR_W = 4;
  localparam int unsigned ID_W = 32;

  // Standard 1149.1 reference encoding, which keeps debug dumps familiar
  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_IDLE         = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  localparam logic [IR_W-1:0] OP_EXTEST = 4'b0000;
  localparam logic [IR_W-1:0] OP_SAMPLE = 4'b0001;
  localparam logic [IR_W-1:0] OP_INTEST = 4'b0010;
  localparam logic [IR_W-1:0] OP_IDCODE = 4'b1110;
  localparam logic [IR_W-1:0] OP_BYPASS = 4'b1111;

  localparam logic [IR_W-1:0] IR_CAPTURE     = 4'b0001;
  localparam logic [ID_W-1:0] IDCODE_DEFAULT = 32'h1923_4001;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TEST_LOGIC_RESET;
    case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_IDLE;
      RUN_IDLE:         n = tms ? SELECT_DR        : RUN_IDLE;
      SELECT_DR:        n = tms ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR        : RUN_IDLE;
      SELECT_IR:        n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR        : RUN_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

  function automatic logic is_bsr_op(input logic [IR_W-1:0] op);
    return (op == OP_EXTEST) || (op == OP_SAMPLE) || (op == OP_INTEST);
  endfunction

  function automatic logic is_bs_en_op(input logic [IR_W-1:0] op);
    return (op == OP_EXTEST) || (op == OP_INTEST);
  endfunction

endpackage

// File: rtl/jtag_clk_gate.sv
// Glitch-free clock gate: enable is captured while clk is low and ANDed with
// clk, so every output pulse is a whole high phase of clk.
module jtag_clk_gate (
  input  logic clk,
  input  logic en,
  output logic gclk
);

  logic en_lat;

  always_latch begin
    if (!clk) en_lat <= en;
  end

  assign gclk = clk & en_lat;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller for the s9234 boundary-scan chain: TAP FSM,
// 4-bit IR, IDCODE and BYPASS registers, BSR control strobes and TDO mux.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter logic [ID_W-1:0] IDCODE = IDCODE_DEFAULT
) (
  input  logic            tck,
  input  logic            reset,
  input  logic            tms,
  input  logic            tdi,
  output logic            tdo,
  output logic            tdo_en,
  output logic            bsr_tdi,
  input  logic            tdo_bsr,
  output logic            clockdr,
  output logic            updatedr,
  output logic            shiftdr,
  output logic            bs_en,
  output logic [3:0]      tap_state,
  output logic [IR_W-1:0] ir_q
);

  tap_state_t      state;
  tap_state_t      state_nxt;
  logic [IR_W-1:0] ir_sr;
  logic [IR_W-1:0] ir_nxt;
  logic [ID_W-1:0] id_sr;
  logic            bypass_q;
  logic            bsr_sel;
  logic            id_sel;
  logic            cd_en;
  logic            ud_en;
  logic            shiftdr_nxt;
  logic            tdo_en_nxt;
  logic            bs_en_nxt;

  // State register
  always_ff @(posedge tck) begin
    if (reset) state <= TEST_LOGIC_RESET;
    else       state <= state_nxt;
  end

  // Next state, next registered outputs, gate enables and TDO mux
  always_comb begin
    state_nxt   = tap_next(state, tms);
    ir_nxt      = ir_q;
    bsr_sel     = is_bsr_op(ir_q);
    id_sel      = (ir_q == OP_IDCODE);
    cd_en       = 1'b0;
    ud_en       = 1'b0;
    tdo         = 1'b0;

    if (state_nxt == TEST_LOGIC_RESET) ir_nxt = OP_IDCODE;
    else if (state == UPDATE_IR)       ir_nxt = ir_sr;

    bs_en_nxt   = is_bs_en_op(ir_nxt);
    shiftdr_nxt = (state_nxt == SHIFT_DR);
    tdo_en_nxt  = (state_nxt == SHIFT_DR) || (state_nxt == SHIFT_IR);

    // Reset kills the enables in the low phase so the reset edge never strobes the BSR
    if (!reset && bsr_sel) begin
      cd_en = (state == CAPTURE_DR) || (state == SHIFT_DR);
      ud_en = (state == UPDATE_DR);
    end

    case (state)
      SHIFT_IR: tdo = ir_sr[0];
      SHIFT_DR: begin
        if (bsr_sel)     tdo = tdo_bsr;
        else if (id_sel) tdo = id_sr[0];
        else             tdo = bypass_q;
      end
      default:  tdo = 1'b0;
    endcase
  end

  // IR, IDCODE and bypass registers plus registered Moore outputs
  always_ff @(posedge tck) begin
    if (reset) begin
      ir_q     <= OP_IDCODE;
      ir_sr    <= IR_CAPTURE;
      id_sr    <= '0;
      bypass_q <= 1'b0;
      bs_en    <= 1'b0;
      shiftdr  <= 1'b0;
      tdo_en   <= 1'b0;
    end else begin
      ir_q    <= ir_nxt;
      bs_en   <= bs_en_nxt;
      shiftdr <= shiftdr_nxt;
      tdo_en  <= tdo_en_nxt;
      case (state)
        CAPTURE_IR: ir_sr <= IR_CAPTURE;
        SHIFT_IR:   ir_sr <= {tdi, ir_sr[IR_W-1:1]};
        CAPTURE_DR: begin
          id_sr    <= IDCODE;
          bypass_q <= 1'b0;
        end
        SHIFT_DR: begin
          if (id_sel)        id_sr    <= {tdi, id_sr[ID_W-1:1]};
          else if (!bsr_sel) bypass_q <= tdi;
        end
        default: ;
      endcase
    end
  end

  assign tap_state = state;
  assign bsr_tdi   = tdi;

  jtag_clk_gate u_clockdr_gate (
    .clk  (tck),
    .en   (cd_en),
    .gclk (clockdr)
  );

  jtag_clk_gate u_updatedr_gate (
    .clk  (tck),
    .en   (ud_en),
    .gclk (updatedr)
  );

endmodule
